// File: rtl/pattern_generator.sv
// Transmit-side test-pattern source: emits one WIDTH-bit word every PERIOD clocks
// (counter / PRBS7 / walking one / alternating) with optional single-bit error injection.
module pattern_generator #(
   parameter int         WIDTH  = 8,
   parameter int         PERIOD = 4,
   parameter logic [6:0] SEED   = 7'h7F
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             I_EN,
   input  logic [1:0]       I_MODE,
   input  logic             I_INJECT,
   output logic             O_STB,
   output logic [WIDTH-1:0] O_DAT
);

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_PRBS  = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_ALT   = 2'd3
   } mode_t;

   localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
   localparam logic [WIDTH-1:0] WORD_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] alt_pattern();
      logic [WIDTH-1:0] w;
      for (int i = 0; i < WIDTH; i++) w[i] = ((i % 2) == 0);
      return w;
   endfunction

   localparam logic [WIDTH-1:0] ALT_WORD = alt_pattern();

   logic [DIV_W-1:0] div_q;
   mode_t            mode_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] walk_q, walk_d;
   logic [6:0]       prbs_q, prbs_d;
   logic             inj_pend_q, inj_pend_d;

   logic             strobe;
   mode_t            mode_in;
   logic             reinit;
   logic [6:0]       prbs_base;
   logic [6:0]       prbs_state;
   logic [WIDTH-1:0] prbs_word;
   logic [WIDTH-1:0] cnt_base, walk_base;
   logic [WIDTH-1:0] word;

   assign strobe  = I_EN && (div_q == DIV_LAST);
   assign mode_in = mode_t'(I_MODE);
   assign reinit  = (mode_in != mode_q);

   // A mode change restarts that mode's sequence from its initial state.
   assign cnt_base  = reinit ? '0       : cnt_q;
   assign walk_base = reinit ? WORD_ONE : walk_q;
   assign prbs_base = reinit ? SEED     : prbs_q;

   // PRBS7 (x^7+x^6+1) stepped WIDTH times; first generated bit lands in the MSB.
   always_comb begin
      prbs_state = prbs_base;
      prbs_word  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         prbs_word[i] = prbs_state[6] ^ prbs_state[5];
         prbs_state   = {prbs_state[5:0], prbs_word[i]};
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      word   = '0;
      cnt_d  = cnt_q;
      walk_d = walk_q;
      prbs_d = prbs_q;
      if (strobe) begin
         unique case (mode_in)
            MODE_COUNT: begin
               word  = cnt_base;
               cnt_d = cnt_base + 1'b1;
            end
            MODE_PRBS: begin
               word   = prbs_word;
               prbs_d = prbs_state;
            end
            MODE_WALK: begin
               word   = walk_base;
               walk_d = {walk_base[WIDTH-2:0], walk_base[WIDTH-1]};
            end
            MODE_ALT: word = ALT_WORD;
         endcase
      end
   end

   // A pulse on the strobe edge itself is held for the following word.
   assign inj_pend_d = strobe ? I_INJECT : (inj_pend_q | I_INJECT);

   // NOTE: state registers use non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q      <= '0;
         mode_q     <= MODE_COUNT;
         cnt_q      <= '0;
         walk_q     <= WORD_ONE;
         prbs_q     <= SEED;
         inj_pend_q <= 1'b0;
         O_STB      <= 1'b0;
         O_DAT      <= '0;
      end else begin
         inj_pend_q <= inj_pend_d;
         O_STB      <= strobe;
         if (I_EN) div_q <= strobe ? '0 : div_q + 1'b1;
         if (strobe) begin
            mode_q <= mode_in;
            cnt_q  <= cnt_d;
            walk_q <= walk_d;
            prbs_q <= prbs_d;
            O_DAT  <= word ^ {{(WIDTH-1){1'b0}}, inj_pend_q};
         end
      end
   end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: expected words are queued as stimulus is
// applied and popped when the DUT strobes.
module tb_pattern_generator;

   localparam int         WIDTH = 8;
   localparam logic [6:0] SEED  = 7'h7F;

   logic             CLK = 1'b0;
   logic             RST;
   logic             I_EN;
   logic [1:0]       I_MODE;
   logic             I_INJECT;
   logic             O_STB;
   logic [WIDTH-1:0] O_DAT;

   logic             en1;
   logic             stb1;
   logic [WIDTH-1:0] dat1;

   int evals = 0;
   int fails = 0;
   int cyc = 0;
   int last_stb_cyc = 0;
   logic [7:0] last_dat = '0;
   logic [7:0] exp_q[$];
   logic [7:0] hist[$];

   always #5 CLK = ~CLK;

   pattern_generator #(.WIDTH(WIDTH), .PERIOD(4), .SEED(SEED)) dut (
      .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_MODE(I_MODE), .I_INJECT(I_INJECT),
      .O_STB(O_STB), .O_DAT(O_DAT)
   );

   pattern_generator #(.WIDTH(WIDTH), .PERIOD(1), .SEED(SEED)) dut_p1 (
      .CLK(CLK), .RST(RST), .I_EN(en1), .I_MODE(2'b00), .I_INJECT(1'b0),
      .O_STB(stb1), .O_DAT(dat1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      cyc++;
   endtask

   task automatic take_word(input string tag, input int gap);
      logic [7:0] e;
      check($sformatf("%s stb", tag), 32'(O_STB), 32'd1);
      if (gap > 0) check($sformatf("%s gap", tag), 32'(cyc - last_stb_cyc), 32'(gap));
      if (exp_q.size() == 0) begin
         evals++;
         fails++;
         $error("FAIL %s: observed 0x%0h expected nothing queued", tag, O_DAT);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(O_DAT), 32'(e));
         last_dat = e;
      end
      hist.push_back(O_DAT);
      last_stb_cyc = cyc;
   endtask

   task automatic wait_stb(input string tag, input int gap);
      int n = 0;
      do begin
         step();
         n++;
         if (!O_STB) check($sformatf("%s hold", tag), 32'(O_DAT), 32'(last_dat));
      end while (!O_STB && n < 20);
      if (!O_STB) begin
         evals++;
         fails++;
         $error("FAIL %s timeout: observed no strobe expected one within 20 cycles", tag);
      end else begin
         take_word(tag, gap);
      end
   endtask

   task automatic prbs_model(inout logic [6:0] s, output logic [7:0] w);
      logic b;
      w = '0;
      for (int j = 7; j >= 0; j--) begin
         b    = s[6] ^ s[5];
         w[j] = b;
         s    = {s[5:0], b};
      end
   endtask

   initial begin : stim
      logic [6:0]   s;
      logic [7:0]   w;
      logic [7:0]   hw;
      logic [0:253] bits;
      logic         mism;

      RST = 1'b1; I_EN = 1'b0; I_MODE = 2'd0; I_INJECT = 1'b0; en1 = 1'b0;
      #12;
      check("reset stb", 32'(O_STB), 32'd0);
      check("reset dat", 32'(O_DAT), 32'd0);
      check("reset stb p1", 32'(stb1), 32'd0);
      check("reset dat p1", 32'(dat1), 32'd0);
      step();
      RST = 1'b0;
      I_EN = 1'b1;
      last_stb_cyc = cyc;
      last_dat = '0;

      // counter cadence and wrap
      for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
      exp_q.push_back(8'h00);
      for (int k = 0; k < 257; k++) wait_stb($sformatf("ctr %0d", k), 4);
      for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
      for (int k = 1; k <= 5; k++) wait_stb($sformatf("ctr %0d", k), 4);

      // single injection between words 5 and 6
      I_INJECT = 1'b1; step(); I_INJECT = 1'b0;
      exp_q.push_back(8'h07); exp_q.push_back(8'h07);
      wait_stb("inj single", 4);
      wait_stb("inj single next", 4);

      // two pulses in one interval collapse into one corruption
      I_INJECT = 1'b1; step(); I_INJECT = 1'b0; step();
      I_INJECT = 1'b1; step(); I_INJECT = 1'b0;
      exp_q.push_back(8'h09); exp_q.push_back(8'h09);
      wait_stb("inj double", 4);
      wait_stb("inj double next", 4);

      // pulse coincident with a strobe edge lands one word later
      step(); step(); step();
      I_INJECT = 1'b1; step(); I_INJECT = 1'b0;
      exp_q.push_back(8'h0A);
      take_word("inj edge", 4);
      exp_q.push_back(8'h0A); exp_q.push_back(8'h0C);
      wait_stb("inj edge later", 4);
      wait_stb("inj edge after", 4);

      // enable dropped with div=2
      step(); step();
      I_EN = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("en off stb %0d", k), 32'(O_STB), 32'd0);
         check($sformatf("en off dat %0d", k), 32'(O_DAT), 32'h0C);
      end
      I_EN = 1'b1;
      last_stb_cyc = cyc;
      exp_q.push_back(8'h0D);
      wait_stb("en resume", 2);

      // PRBS7 entry mid-stream
      I_MODE = 2'd1;
      s = SEED;
      hist.delete();
      for (int k = 0; k < 127; k++) begin
         prbs_model(s, w);
         exp_q.push_back(k == 0 ? 8'h02 : (k == 1 ? 8'h0C : w));
      end
      for (int k = 0; k < 127; k++) wait_stb($sformatf("prbs %0d", k), 4);

      for (int k = 0; k < 32; k++) begin
         hw = hist[k];
         for (int j = 0; j < 8; j++)
            if (8 * k + j < 254) bits[8 * k + j] = hw[7 - j];
      end
      mism = 1'b0;
      for (int i = 0; i < 127; i++) mism |= (bits[i] !== bits[i + 127]);
      check("prbs period 127", 32'(mism), 32'd0);

      // asynchronous reset between edges while PRBS runs
      #1 RST = 1'b1;
      #1;
      check("async rst stb", 32'(O_STB), 32'd0);
      check("async rst dat", 32'(O_DAT), 32'd0);
      step();
      RST = 1'b0;
      last_stb_cyc = cyc;
      last_dat = '0;
      exp_q.push_back(8'h02); exp_q.push_back(8'h0C);
      wait_stb("prbs after rst 0", 4);
      wait_stb("prbs after rst 1", 4);

      // walking one, then alternating mid-interval
      I_MODE = 2'd2;
      for (int k = 0; k < 8; k++) exp_q.push_back(8'(1 << k));
      exp_q.push_back(8'h01);
      for (int k = 0; k < 9; k++) wait_stb($sformatf("walk %0d", k), 4);
      step(); step();
      I_MODE = 2'd3;
      for (int k = 0; k < 4; k++) exp_q.push_back(8'h55);
      for (int k = 0; k < 4; k++) wait_stb($sformatf("alt %0d", k), 4);

      // PERIOD=1: strobe stays high, counter advances every clock
      en1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         check($sformatf("p1 stb %0d", k), 32'(stb1), 32'd1);
         check($sformatf("p1 dat %0d", k), 32'(dat1), 32'(k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
      $finish;
   end

endmodule
